// File: rtl/csa_pipe_adder.sv
// ============================================================================
// csa_pipe_adder : pipelined carry-select adder/subtractor, one SEG-bit
//                  segment resolved per stage, valid/ready with full stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csa_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / SEG;

    // Generate/propagate ripple across one segment; returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           ci
    );
        logic [SEG:0]   c;
        logic [SEG-1:0] s;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
        return {c[SEG], s};
    endfunction

    logic [WIDTH-1:0] a_q     [NSTG];
    logic [WIDTH-1:0] a_d     [NSTG];
    logic [WIDTH-1:0] b_q     [NSTG];
    logic [WIDTH-1:0] b_d     [NSTG];
    logic [WIDTH-1:0] sum_q   [NSTG];
    logic [WIDTH-1:0] sum_d   [NSTG];
    logic             carry_q [NSTG];
    logic             carry_d [NSTG];
    logic             valid_q [NSTG];
    logic             valid_d [NSTG];
    logic             msb_c_q;
    logic             msb_c_d;
    logic             en;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[NSTG-1];
    assign result    = sum_q[NSTG-1];
    assign cout      = carry_q[NSTG-1];
    assign ovf       = msb_c_q ^ carry_q[NSTG-1];

    genvar k;
    generate
        for (k = 0; k < NSTG; k++) begin : g_stage
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;
            logic [WIDTH-1:0] s_in;
            logic             c_in;
            logic             v_in;
            logic [SEG:0]     r0;
            logic [SEG:0]     r1;
            logic [SEG:0]     rs;
            logic [WIDTH-1:0] sum_n;

            if (k == 0) begin : g_head
                assign a_in = op_a;
                assign b_in = sub ? ~op_b : op_b;
                assign c_in = cin ^ sub;
                assign s_in = '0;
                assign v_in = in_valid;
            end else begin : g_tail
                assign a_in = a_q[k-1];
                assign b_in = b_q[k-1];
                assign c_in = carry_q[k-1];
                assign s_in = sum_q[k-1];
                assign v_in = valid_q[k-1];
            end

            assign r0 = seg_add(a_in[k*SEG +: SEG], b_in[k*SEG +: SEG], 1'b0);
            assign r1 = seg_add(a_in[k*SEG +: SEG], b_in[k*SEG +: SEG], 1'b1);
            assign rs = c_in ? r1 : r0;

            always_comb begin
                sum_n                = s_in;
                sum_n[k*SEG +: SEG]  = rs[SEG-1:0];
            end

            assign a_d[k]     = a_in;
            assign b_d[k]     = b_in;
            assign sum_d[k]   = sum_n;
            assign carry_d[k] = rs[SEG];
            assign valid_d[k] = v_in;

            // Carry into the MSB recovered from the sum bit and the operand bits.
            if (k == NSTG - 1) begin : g_last
                assign msb_c_d = rs[SEG-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) begin
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                sum_q[i]   <= '0;
                carry_q[i] <= 1'b0;
                valid_q[i] <= 1'b0;
            end
            msb_c_q <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < NSTG; i++) begin
                a_q[i]     <= a_d[i];
                b_q[i]     <= b_d[i];
                sum_q[i]   <= sum_d[i];
                carry_q[i] <= carry_d[i];
                valid_q[i] <= valid_d[i];
            end
            msb_c_q <= msb_c_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
// ============================================================================
// tb_csa_pipe_adder : scoreboard bench for csa_pipe_adder (WIDTH=32, SEG=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csa_pipe_adder;

    localparam int W = 32;
    localparam int S = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a      = '0;
    logic [W-1:0] op_b      = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    logic [W+1:0] exp_cur   = '0;
    logic [W+1:0] sb [$];
    int           passed    = 0;
    int           total     = 0;
    logic         rand_rdy  = 1'b0;
    logic         bp_arm    = 1'b0;
    logic         bp_fired  = 1'b0;
    int           hold_left = 0;
    logic [W-1:0] held      = '0;
    int           lat;

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(W), .SEG(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input logic ok, input string name,
                       input logic [W+1:0] act, input logic [W+1:0] expv);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference: {cout, signed overflow, sum} from operand signs and sum sign.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic s);
        logic [W-1:0] be;
        logic [W:0]   t;
        logic         v;
        be = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci ^ s};
        v  = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        return {t[W], v, t[W-1:0]};
    endfunction

    // Monitor: handshakes are stable from posedge+1 to the next posedge.
    always @(negedge clk) begin : mon
        logic [W+1:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_output", {cout, ovf, result}, '0);
                end else begin
                    e = sb.pop_front();
                    chk({cout, ovf, result} === e, "result", {cout, ovf, result}, e);
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
        end
    end

    task automatic step_prep();
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (bp_arm && out_valid) begin
            bp_arm    = 1'b0;
            bp_fired  = 1'b1;
            hold_left = 3;
            held      = result;
        end
        if (hold_left > 0) out_ready = 1'b0;
        #1;
        if (hold_left > 0) begin
            chk(!in_ready, "in_ready_stall", (W+2)'(in_ready), '0);
            chk(out_valid && result == held, "held_result",
                {1'b0, out_valid, result}, {2'b01, held});
            hold_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step_prep();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s, input logic [W+1:0] e);
        logic acc;
        acc      = 1'b0;
        op_a     = a;
        op_b     = b;
        cin      = ci;
        sub      = s;
        exp_cur  = e;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            step_prep();
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk(1'b0, "send_timeout", '0, (W+2)'(1));
    endtask

    task automatic drain();
        for (int t = 0; t < 80 && sb.size() != 0; t++) idle(1);
        chk(sb.size() == 0, "drain", (W+2)'(sb.size()), '0);
    endtask

    initial begin : wdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk(!out_valid, "reset_out_valid", (W+2)'(out_valid), '0);
        chk(result == '0, "reset_result", (W+2)'(result), '0);
        chk(in_ready, "reset_in_ready", (W+2)'(in_ready), (W+2)'(1));
        chk(!cout && !ovf, "reset_cout_ovf", (W+2)'({cout, ovf}), '0);
        @(posedge clk);
        #1;

        // Carry across the first segment boundary, plus latency measurement.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0100});
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk(lat == 4, "latency", (W+2)'(lat), (W+2)'(4));
        drain();

        // Directed back-to-back: {cout, ovf, result} computed by hand.
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
        send(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, {1'b1, 1'b0, 32'h0000_000C});
        send(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, {1'b0, 1'b0, 32'h9999_9999});
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, {1'b1, 1'b1, 32'h0000_0001});
        drain();

        // Six back-to-back ops; output stalls 3 cycles once the first is valid.
        bp_arm = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ra = 32'h1111_1111 * (i + 1);
            rb = 32'h0F0F_0F0F << i;
            rc = i[0];
            rs = i[1];
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drain();
        chk(bp_fired, "backpressure_seen", (W+2)'(bp_fired), (W+2)'(1));

        // Reset with three ops in flight; none of them may surface later.
        for (int i = 0; i < 3; i++) send(32'hA5A5_0000 + i, 32'h0000_1000, 1'b0, 1'b0,
                                         model(32'hA5A5_0000 + i, 32'h0000_1000, 1'b0, 1'b0));
        rst = 1'b1;
        sb.delete();
        #1;
        chk(!out_valid, "rst_async_out_valid", (W+2)'(out_valid), '0);
        @(posedge clk);
        #1;
        chk(!out_valid, "rst_next_out_valid", (W+2)'(out_valid), '0);
        rst = 1'b0;
        idle(10);
        chk(!out_valid, "rst_no_stale", (W+2)'(out_valid), '0);

        // Random ops with random bubbles and random output backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        rand_rdy = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
